bch_stream_collect: RTL and testbench

Receive-side framer for the BCH byte stream emitted by `xilinx_encode`. It consumes the `data_in`/`first`/`last`/`data_bits`/`ecc_bits` beat stream, reassembles it into one parallel data word and one parallel ECC word, checks framing, and presents the codeword with a valid/ack handshake. It sits between the encoder output, or the channel model in the bench, and the downstream syndrome/decoder stage, and is the parallel counterpart of `buff`.

---
 rtl/bch_stream_collect_pkg.sv | 15 +
 rtl/bch_stream_collect_if.sv | 33 +++
 rtl/bch_shift_in.sv | 23 ++
 rtl/bch_stream_collect.sv | 92 +++++++++
 tb/tb_bch_stream_collect.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bch_stream_collect_pkg.sv
// bch_stream_collect_pkg: shared state encoding, default geometry and beat-count helpers
// Contents: DEF_* default frame geometry, state_t collector states,
//           beats() payload/parity beat count, cnt_width() beat counter width.
package bch_stream_collect_pkg;
    localparam int DEF_DATA_BITS = 192;
    localparam int DEF_ECC_BITS = 64;
    localparam int DEF_BITS = 8;
    typedef enum logic [1:0] {IDLE, DATA, ECC, DONE} state_t;
    function automatic int beats(input int bits, input int step);
        return bits / step;
    endfunction
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction
endpackage

// File: rtl/bch_stream_collect_if.sv
// bch_stream_collect_if: beat stream in, parallel codeword out with valid/ack
// master: drives ce, data_in, first, last, data_bits, ecc_bits, ack
//         and observes data_out, ecc_out, valid, frame_err, overrun, busy.
// slave:  the collector, the mirror image of master.
interface bch_stream_collect_if
    import bch_stream_collect_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ECC_BITS = DEF_ECC_BITS,
    parameter int BITS = DEF_BITS
);
    logic ce;
    logic [BITS-1:0] data_in;
    logic first;
    logic last;
    logic data_bits;
    logic ecc_bits;
    logic ack;
    logic [DATA_BITS-1:0] data_out;
    logic [ECC_BITS-1:0] ecc_out;
    logic valid;
    logic frame_err;
    logic overrun;
    logic busy;
    modport master(
        output ce, data_in, first, last, data_bits, ecc_bits, ack,
        input data_out, ecc_out, valid, frame_err, overrun, busy
    );
    modport slave(
        input ce, data_in, first, last, data_bits, ecc_bits, ack,
        output data_out, ecc_out, valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/bch_shift_in.sv
// bch_shift_in: W-bit register that shifts left by BITS, taking d at the LSB end
// Ports: clk_in clock, rst async active-high clear, en shift enable,
//        d incoming beat, q register contents (oldest beat in the MSBs).
module bch_shift_in #(
    parameter int W = 64,
    parameter int BITS = 8
) (
    input logic clk_in,
    input logic rst,
    input logic en,
    input logic [BITS-1:0] d,
    output logic [W-1:0] q
);
    if (W > BITS) begin : g_shift
        always_ff @(posedge clk_in or posedge rst)
            if (rst) q <= '0;
            else if (en) q <= {q[W-BITS-1:0], d};
    end else begin : g_load
        always_ff @(posedge clk_in or posedge rst)
            if (rst) q <= '0;
            else if (en) q <= d;
    end
endmodule

// File: rtl/bch_stream_collect.sv
// bch_stream_collect: reassembles a BCH beat stream into parallel data/ECC words and checks framing
// Ports: clk_in clock, rst async active-high reset,
//        s (slave) beat inputs ce/data_in/first/last/data_bits/ecc_bits, ack;
//        outputs data_out/ecc_out codeword, valid, frame_err, overrun, busy.
module bch_stream_collect
    import bch_stream_collect_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ECC_BITS = DEF_ECC_BITS,
    parameter int BITS = DEF_BITS
) (
    input logic clk_in,
    input logic rst,
    bch_stream_collect_if.slave s
);
    localparam int DATA_BEATS = beats(DATA_BITS, BITS);
    localparam int ECC_BEATS = beats(ECC_BITS, BITS);
    localparam int CW = cnt_width(DATA_BEATS, ECC_BEATS);
    localparam logic [CW-1:0] DB_LAST = CW'(DATA_BEATS);
    localparam logic [CW-1:0] EB_LAST = CW'(ECC_BEATS);
    // A one-beat payload is complete as soon as its first beat lands.
    localparam state_t START_ST = DATA_BEATS == 1 ? ECC : DATA;
    localparam logic [CW-1:0] START_CNT = DATA_BEATS == 1 ? '0 : CW'(1);
    if ((DATA_BITS % BITS) != 0 || (ECC_BITS % BITS) != 0) begin : g_bad_geometry
        $error("DATA_BITS and ECC_BITS must be multiples of BITS");
    end
    state_t state, state_n;
    logic [CW-1:0] count, count_n, count_inc;
    logic err, err_n, ovr, ovr_n, ld_data, ld_ecc, beat, start, both, take;
    assign beat = s.ce & (s.data_bits | s.ecc_bits);
    assign start = beat & s.data_bits & s.first;
    assign both = s.data_bits & s.ecc_bits;
    assign count_inc = count + 1'b1;
    // A first beat opens a frame from IDLE, restarts a clean collection, or follows an ack.
    assign take = start & (state == DONE ? s.ack : (state == IDLE || !both));
    always_comb begin
        state_n = state;
        count_n = count;
        err_n = err;
        ovr_n = ovr;
        ld_data = 1'b0;
        ld_ecc = 1'b0;
        case (state)
            IDLE: ;
            DATA: if (beat) begin
                ld_data = s.data_bits & !both;
                state_n = both || !s.data_bits ? DONE : (count_inc == DB_LAST ? ECC : DATA);
                count_n = s.data_bits && count_inc != DB_LAST ? count_inc : '0;
                err_n = both || !s.data_bits;
            end
            ECC: if (beat) begin
                ld_ecc = s.ecc_bits & !both;
                count_n = count_inc;
                state_n = !s.ecc_bits || both || s.last || count_inc == EB_LAST ? DONE : ECC;
                err_n = !s.ecc_bits || both || (count_inc == EB_LAST ? !s.last : s.last);
            end
            DONE: begin
                state_n = s.ack ? IDLE : DONE;
                ovr_n = !s.ack & (ovr | beat);
            end
        endcase
        if (take) begin
            ld_data = 1'b1;
            ld_ecc = 1'b0;
            state_n = START_ST;
            count_n = START_CNT;
            err_n = 1'b0;
        end
    end
    always_ff @(posedge clk_in or posedge rst)
        if (rst) begin
            state <= IDLE;
            count <= '0;
            err <= 1'b0;
            ovr <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            err <= err_n;
            ovr <= ovr_n;
        end
    assign s.valid = state == DONE;
    assign s.busy = state == DATA || state == ECC;
    assign s.frame_err = (state == DONE) & err;
    assign s.overrun = ovr;
    bch_shift_in #(.W(DATA_BITS), .BITS(BITS)) u_data (
        .clk_in(clk_in), .rst(rst), .en(ld_data), .d(s.data_in), .q(s.data_out)
    );
    bch_shift_in #(.W(ECC_BITS), .BITS(BITS)) u_ecc (
        .clk_in(clk_in), .rst(rst), .en(ld_ecc), .d(s.data_in), .q(s.ecc_out)
    );
endmodule

// File: tb/tb_bch_stream_collect.sv
// tb_bch_stream_collect: randomized and directed frames checked against a beat-queue model
module tb_bch_stream_collect;
    localparam int DB = 192;
    localparam int EW = 64;
    localparam int B = 8;
    localparam int ND = DB / B;
    localparam int NE = EW / B;
    localparam logic [DB-1:0] GD = 192'h123456789ABCDEF0123456789ABCDEF0123456789ABCDEF1;
    localparam logic [EW-1:0] GE = 64'h5A3C96E10F7BD248;
    localparam logic [DB-1:0] GD2 = 192'hFEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF;
    localparam logic [EW-1:0] GE2 = 64'h0123456789ABCDEF;
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    always #5 clk_in = ~clk_in;
    bch_stream_collect_if #(.DATA_BITS(DB), .ECC_BITS(EW), .BITS(B)) bus ();
    bch_stream_collect #(.DATA_BITS(DB), .ECC_BITS(EW), .BITS(B)) dut (
        .clk_in(clk_in), .rst(rst), .s(bus)
    );
    task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    // Model: a frame is the list of beats collected so far; its phase is implied by how many arrived.
    bit m_coll = 0, m_held = 0, m_err = 0, m_ovr = 0;
    logic [B-1:0] dq[$];
    logic [B-1:0] eq[$];
    logic [DB-1:0] m_data = '0;
    logic [EW-1:0] m_ecc = '0;
    task automatic m_begin();
        dq.delete();
        eq.delete();
        dq.push_back(bus.data_in);
        m_coll = 1;
        m_err = 0;
    endtask
    task automatic m_present(input bit e);
        m_coll = 0;
        m_held = 1;
        m_err = e;
        m_data = '0;
        m_ecc = '0;
        foreach (dq[i]) m_data = (m_data << B) | DB'(dq[i]);
        foreach (eq[i]) m_ecc = (m_ecc << B) | EW'(eq[i]);
    endtask
    always @(posedge clk_in or posedge rst) begin
        bit beat, start;
        if (rst) begin
            m_coll = 0;
            m_held = 0;
            m_err = 0;
            m_ovr = 0;
            dq.delete();
            eq.delete();
        end else begin
            beat = bus.ce && (bus.data_bits || bus.ecc_bits);
            start = beat && bus.data_bits && bus.first;
            if (m_held) begin
                if (bus.ack) begin
                    m_held = 0;
                    m_ovr = 0;
                    if (start) m_begin();
                end else if (beat) m_ovr = 1;
            end else if (!m_coll) begin
                if (start) m_begin();
            end else if (beat) begin
                if (bus.data_bits && bus.ecc_bits) m_present(1);
                else if (start) m_begin();
                else if (dq.size() < ND) begin
                    if (bus.data_bits) dq.push_back(bus.data_in);
                    else m_present(1);
                end else if (bus.ecc_bits) begin
                    eq.push_back(bus.data_in);
                    if (eq.size() == NE) m_present(!bus.last);
                    else if (bus.last) m_present(1);
                end else m_present(1);
            end
        end
    end
    always @(negedge clk_in) if (!rst) begin
        chk("valid", DB'(bus.valid), DB'(m_held));
        chk("busy", DB'(bus.busy), DB'(m_coll));
        chk("overrun", DB'(bus.overrun), DB'(m_ovr));
        if (m_held) begin
            chk("frame_err", DB'(bus.frame_err), DB'(m_err));
            if (!m_err) begin
                chk("data_out", bus.data_out, m_data);
                chk("ecc_out", DB'(bus.ecc_out), DB'(m_ecc));
            end
        end
    end
    task automatic cyc(input bit c, input logic [B-1:0] d, input bit f, input bit l,
                       input bit db, input bit eb, input bit a);
        bus.ce = c;
        bus.data_in = d;
        bus.first = f;
        bus.last = l;
        bus.data_bits = db;
        bus.ecc_bits = eb;
        bus.ack = a;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask
    // early: 1-based ECC beat carrying an early last (0 = none); ndata < ND stops after the data beats.
    task automatic frame(input logic [DB-1:0] dw, input logic [EW-1:0] ew, input int early,
                         input bit nolast, input bit tog, input int ndata, input bit af);
        for (int i = 0; i < ndata; i++) begin
            if (tog) cyc(0, B'($urandom), 1, 0, 1, 0, 0);
            cyc(1, dw[DB-1-B*i -: B], i == 0, 0, 1, 0, af && i == 0);
        end
        if (ndata < ND) return;
        for (int j = 0; j < NE; j++) begin
            if (tog) cyc(0, B'($urandom), 0, 1, 0, 1, 0);
            cyc(1, ew[EW-1-B*j -: B], 0, early != 0 ? j + 1 == early : (j == NE - 1 && !nolast), 0, 1, 0);
            if (early != 0 && j + 1 == early) break;
        end
    endtask
    task automatic ack_cycle();
        cyc(0, '0, 0, 0, 0, 0, 1);
    endtask
    initial begin
        logic [DB-1:0] rd;
        logic [EW-1:0] re;
        int mode, n;
        bus.ce = 0; bus.data_in = '0; bus.first = 0; bus.last = 0;
        bus.data_bits = 0; bus.ecc_bits = 0; bus.ack = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_valid", DB'(bus.valid), '0);
        chk("rst_busy", DB'(bus.busy), '0);
        chk("rst_data", bus.data_out, '0);
        chk("rst_ecc", DB'(bus.ecc_out), '0);
        rst = 0;
        @(negedge clk_in);
        frame(GD, GE, 0, 0, 0, ND, 0);
        chk("gold_valid", DB'(bus.valid), 1);
        chk("gold_data", bus.data_out, GD);
        chk("gold_ecc", DB'(bus.ecc_out), DB'(GE));
        chk("gold_err", DB'(bus.frame_err), 0);
        ack_cycle();
        chk("gold_ack", DB'(bus.valid), 0);
        frame(GD2, GE2, 0, 0, 1, ND, 0);
        chk("tog_valid", DB'(bus.valid), 1);
        chk("tog_data", bus.data_out, GD2);
        chk("tog_ecc", DB'(bus.ecc_out), DB'(GE2));
        ack_cycle();
        frame(GD, GE, 5, 0, 0, ND, 0);
        chk("early_last_valid", DB'(bus.valid), 1);
        chk("early_last_err", DB'(bus.frame_err), 1);
        ack_cycle();
        frame(GD, GE, 0, 1, 0, ND, 0);
        chk("no_last_err", DB'(bus.frame_err), 1);
        ack_cycle();
        frame(GD, GE, 0, 0, 0, 9, 0);
        frame(GD2, GE2, 0, 0, 0, ND, 0);
        chk("restart_err", DB'(bus.frame_err), 0);
        chk("restart_data", bus.data_out, GD2);
        ack_cycle();
        frame(GD, GE, 0, 0, 0, ND, 0);
        frame(GD2, GE2, 0, 0, 0, ND, 0);
        chk("ovr_flag", DB'(bus.overrun), 1);
        chk("ovr_hold", bus.data_out, GD);
        ack_cycle();
        chk("ovr_ack_valid", DB'(bus.valid), 0);
        chk("ovr_ack_clear", DB'(bus.overrun), 0);
        frame(GD, GE, 0, 0, 0, 11, 0);
        rst = 1;
        #1;
        chk("mid_rst_busy", DB'(bus.busy), 0);
        chk("mid_rst_data", bus.data_out, '0);
        chk("mid_rst_err", DB'(bus.frame_err), 0);
        @(negedge clk_in);
        rst = 0;
        frame(GD2, GE2, 0, 0, 0, ND, 0);
        chk("post_rst_data", bus.data_out, GD2);
        chk("post_rst_ecc", DB'(bus.ecc_out), DB'(GE2));
        frame(GD, GE, 0, 0, 0, ND, 1);
        chk("b2b_data", bus.data_out, GD);
        chk("b2b_err", DB'(bus.frame_err), 0);
        ack_cycle();
        for (int k = 0; k < 40; k++) begin
            rd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            re = {$urandom, $urandom};
            mode = int'($urandom_range(0, 9));
            n = int'($urandom_range(1, ND - 1));
            case (mode)
                0: frame(rd, re, int'($urandom_range(1, NE - 1)), 0, $urandom_range(0, 1) == 1, ND, 0);
                1: frame(rd, re, 0, 1, 0, ND, 0);
                2: begin
                    frame(re, re, 0, 0, 0, n, 0);
                    frame(rd, re, 0, 0, $urandom_range(0, 1) == 1, ND, 0);
                end
                3: begin
                    frame(rd, re, 0, 0, 0, n, 0);
                    cyc(1, B'($urandom), 0, 0, 1, 1, 0);
                end
                4: begin
                    frame(rd, re, 0, 0, 0, n, 0);
                    cyc(1, B'($urandom), 0, 0, 0, 1, 0);
                end
                default: frame(rd, re, 0, 0, $urandom_range(0, 1) == 1, ND, 0);
            endcase
            repeat ($urandom_range(0, 3))
                cyc($urandom_range(0, 1) == 1, B'($urandom), $urandom_range(0, 1) == 1, 0,
                    $urandom_range(0, 1) == 1, 0, 0);
            ack_cycle();
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
